// File: rtl/vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Brief    : 640x480@60 raster generator with divide-by-two pixel enable.
//  Revision : 1.0
// ============================================================================
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic        pixel_clk,
   input  logic        reset,
   output logic        count,
   output logic [10:0] hcounter,
   output logic [10:0] vcounter,
   output logic        blank,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] C_V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        C_SYNC_ON  = (SYNC_POL != 0);
   localparam logic        C_SYNC_OFF = !C_SYNC_ON;

   logic        count_q, count_d;
   logic [10:0] hcount_q, hcount_d;
   logic [10:0] vcount_q, vcount_d;
   logic        blank_q, blank_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        frame_end_q, frame_end_d;

   always_comb begin
      count_d  = ~count_q;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (count_q) begin
         // >= rather than == so a corrupted value still wraps on this edge
         if (hcount_q >= C_H_LAST) begin
            hcount_d = 11'd0;
            if (vcount_q >= C_V_LAST) begin
               vcount_d = 11'd0;
            end else begin
               vcount_d = vcount_q + 11'd1;
            end
         end else begin
            hcount_d = hcount_q + 11'd1;
            if (vcount_q > C_V_LAST) begin
               vcount_d = 11'd0;
            end
         end
      end

      // Decodes use next-state counters so they line up with the counters.
      blank_d     = (hcount_d >= C_H_ACT) || (vcount_d >= C_V_ACT);
      hsync_d     = ((hcount_d >= C_HS_START) && (hcount_d < C_HS_END)) ? C_SYNC_ON : C_SYNC_OFF;
      vsync_d     = ((vcount_d >= C_VS_START) && (vcount_d < C_VS_END)) ? C_SYNC_ON : C_SYNC_OFF;
      frame_end_d = count_d && (hcount_d == C_H_LAST) && (vcount_d == C_V_LAST);
   end

   always_ff @(posedge pixel_clk) begin
      if (!reset) begin
         count_q     <= 1'b0;
         hcount_q    <= 11'd0;
         vcount_q    <= 11'd0;
         blank_q     <= 1'b0;
         hsync_q     <= C_SYNC_OFF;
         vsync_q     <= C_SYNC_OFF;
         frame_end_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         blank_q     <= blank_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign count     = count_q;
   assign hcounter  = hcount_q;
   assign vcounter  = vcount_q;
   assign blank     = blank_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign frame_end = frame_end_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing
//  Brief    : Scoreboard bench for vga_timing: default, reduced and inverted-sync instances.
//  Revision : 1.0
// ============================================================================
module tb_vga_timing;

   localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 4;
   localparam int S_VA = 6,  S_VFP = 1, S_VS = 2, S_VBP = 2;
   localparam int S_FRAME = 2 * (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);

   typedef struct packed {
      logic        count;
      logic [10:0] h;
      logic [10:0] v;
      logic        blank;
      logic        hs;
      logic        vs;
      logic        fe;
   } obs_t;

   typedef struct packed {
      obs_t d;
      obs_t s;
      obs_t p;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic        d_count, d_blank, d_hs, d_vs, d_fe;
   logic [10:0] d_h, d_v;
   logic        s_count, s_blank, s_hs, s_vs, s_fe;
   logic [10:0] s_h, s_v;
   logic        p_count, p_blank, p_hs, p_vs, p_fe;
   logic [10:0] p_h, p_v;

   vga_timing u_dflt (
      .pixel_clk (clk), .reset (reset), .count (d_count), .hcounter (d_h), .vcounter (d_v),
      .blank (d_blank), .hsync (d_hs), .vsync (d_vs), .frame_end (d_fe));

   vga_timing #(
      .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
      .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP), .SYNC_POL (0)
   ) u_small (
      .pixel_clk (clk), .reset (reset), .count (s_count), .hcounter (s_h), .vcounter (s_v),
      .blank (s_blank), .hsync (s_hs), .vsync (s_vs), .frame_end (s_fe));

   vga_timing #(
      .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
      .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP), .SYNC_POL (1)
   ) u_pol (
      .pixel_clk (clk), .reset (reset), .count (p_count), .hcounter (p_h), .vcounter (p_v),
      .blank (p_blank), .hsync (p_hs), .vsync (p_vs), .frame_end (p_fe));

   obs_t od, os, op;
   assign od = {d_count, d_h, d_v, d_blank, d_hs, d_vs, d_fe};
   assign os = {s_count, s_h, s_v, s_blank, s_hs, s_vs, s_fe};
   assign op = {p_count, p_h, p_v, p_blank, p_hs, p_vs, p_fe};

   always #10 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   t = 0;
   sb_t  q[$];

   bit   measure_line = 1'b0;
   int   hs_clks = 0, bl_clks = 0, hs_first = -1;
   bit   measure_fe = 1'b0;
   int   fe_n = 0, fe_t0 = -1, fe_t1 = -1;

   // Expected outputs t clocks after the reset-state cycle, from pixel index arithmetic.
   function automatic obs_t model(int tt, int ha, int hfp, int hsw, int hbp,
                                  int va, int vfp, int vsw, int vbp, bit pol);
      obs_t o;
      int ht = ha + hfp + hsw + hbp;
      int vt = va + vfp + vsw + vbp;
      int pix = tt / 2;
      int h = pix % ht;
      int v = (pix / ht) % vt;
      bit ha_on = (h >= ha + hfp) && (h < ha + hfp + hsw);
      bit va_on = (v >= va + vfp) && (v < va + vfp + vsw);
      o.count = tt[0];
      o.h     = h[10:0];
      o.v     = v[10:0];
      o.blank = (h >= ha) || (v >= va);
      o.hs    = pol ? ha_on : !ha_on;
      o.vs    = pol ? va_on : !va_on;
      o.fe    = tt[0] && (h == ht - 1) && (v == vt - 1);
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
      end
   endtask

   task automatic step();
      sb_t e;
      @(posedge clk);
      if (!reset) t = 0;
      else t++;
      e.d = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      e.s = model(t, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b0);
      e.p = model(t, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1);
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      check("dflt", 32'(od), 32'(e.d));
      check("small", 32'(os), 32'(e.s));
      check("pol", 32'(op), 32'(e.p));
      if (measure_line && t < 1600) begin
         if (!d_hs) begin
            hs_clks++;
            if (hs_first < 0) hs_first = t;
         end
         if (d_blank) bl_clks++;
      end
      if (measure_fe && s_fe) begin
         fe_n++;
         if (fe_n == 1) fe_t0 = t;
         if (fe_n == 2) fe_t1 = t;
         check("fe_pos", {9'd0, s_count, s_h, s_v}, {9'd0, 1'b1, 11'(24), 11'(10)});
      end
   endtask

   initial begin
      // Power-up reset, then one default line plus several reduced frames.
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      measure_line = 1'b1;
      repeat (3300) step();
      measure_line = 1'b0;
      check("hs_len", 32'(hs_clks), 32'(192));
      check("hs_start", 32'(hs_first), 32'(2 * 656));
      check("blank_len", 32'(bl_clks), 32'(320));

      // Mid-line reset held for 5 clocks, then two reduced frames.
      repeat (13) step();
      reset = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      measure_fe = 1'b1;
      repeat (1200) step();
      measure_fe = 1'b0;
      check("fe_count", 32'(fe_n), 32'(2));
      check("fe_first", 32'(fe_t0), 32'(S_FRAME - 1));
      check("fe_gap", 32'(fe_t1 - fe_t0), 32'(S_FRAME));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
